// File: rtl/cic_comp_pkg.sv
// Shared constants, FSM encoding and the default coefficient set for the CIC compensation FIR.
package cic_comp_pkg;

  localparam int CIC_DATA_W = 24;
  localparam int CIC_COEF_W = 18;
  localparam int CIC_NTAPS  = 21;
  localparam int CIC_OUT_W  = 24;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MAC   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_ROUND = 2'd3
  } fir_state_e;

  // Symmetric inverse-sinc taps for a 5-stage, M=2 CIC in Q1.17; indices past the table read as zero.
  function automatic logic signed [CIC_COEF_W-1:0] default_coef(input logic [5:0] idx);
    logic signed [CIC_COEF_W-1:0] c;
    case (idx)
      6'd0,  6'd20: c = -18'sd120;
      6'd1,  6'd19: c =  18'sd310;
      6'd2,  6'd18: c = -18'sd650;
      6'd3,  6'd17: c =  18'sd1180;
      6'd4,  6'd16: c = -18'sd2000;
      6'd5,  6'd15: c =  18'sd3250;
      6'd6,  6'd14: c = -18'sd5200;
      6'd7,  6'd13: c =  18'sd8400;
      6'd8,  6'd12: c = -18'sd14300;
      6'd9,  6'd11: c =  18'sd30500;
      6'd10:        c =  18'sd100000;
      default:      c =  18'sd0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/cic_comp_coef_rom.sv
// Coefficient ROM with a registered read; the default Q1.17 table is rescaled to COEF_WIDTH.
module cic_comp_coef_rom
  import cic_comp_pkg::*;
#(
  parameter int COEF_WIDTH = CIC_COEF_W,
  parameter int ADDR_W     = 5
) (
  input  logic                         clk_i,
  input  logic                         rst_n_i,
  input  logic                         en_i,
  input  logic [ADDR_W-1:0]            addr_i,
  output logic signed [COEF_WIDTH-1:0] coef_o
);

  logic signed [COEF_WIDTH-1:0] coef_q, coef_d;

  always_comb begin
    longint v;
    v = longint'(default_coef(6'(addr_i)));
    if (COEF_WIDTH >= CIC_COEF_W) begin
      v = v <<< (COEF_WIDTH - CIC_COEF_W);
    end else begin
      v = v >>> (CIC_COEF_W - COEF_WIDTH);
    end
    coef_d = COEF_WIDTH'(v);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      coef_q <= '0;
    end else if (en_i) begin
      coef_q <= coef_d;
    end
  end

  assign coef_o = coef_q;

endmodule

// File: rtl/cic_comp_fir.sv
// CIC compensation FIR: circular delay line, one registered multiplier, half-up rounding.
// Build option: define CIC_COMP_FIR_SAT_EN to clamp results to the output range instead of wrapping.
module cic_comp_fir
  import cic_comp_pkg::*;
#(
  parameter int DATA_WIDTH = CIC_DATA_W,
  parameter int COEF_WIDTH = CIC_COEF_W,
  parameter int NTAPS      = CIC_NTAPS,
  parameter int OUT_WIDTH  = CIC_OUT_W
) (
  input  logic                         clk_i,
  input  logic                         rst_n_i,
  input  logic                         en_i,
  input  logic signed [DATA_WIDTH-1:0] data_i,
  input  logic                         val_i,
  input  logic                         clr_i,
  output logic signed [OUT_WIDTH-1:0]  data_o,
  output logic                         val_o,
  output logic                         busy_o,
  output logic                         ovf_o
);

  localparam int TW     = $clog2(NTAPS);
  localparam int PROD_W = DATA_WIDTH + COEF_WIDTH;
  localparam int ACC_W  = PROD_W + $clog2(NTAPS);
  localparam logic [TW-1:0] LAST = TW'(NTAPS - 1);
  localparam logic signed [ACC_W-1:0] RND_BIAS = ACC_W'(1) << (COEF_WIDTH - 2);

  fir_state_e                   state_q, state_d;
  logic [TW-1:0]                wptr_q, wptr_d, rptr_q, rptr_d, tap_q, tap_d;
  logic signed [DATA_WIDTH-1:0] line_q [NTAPS];
  logic signed [COEF_WIDTH-1:0] coef_s;
  logic signed [DATA_WIDTH-1:0] samp_s;
  logic signed [PROD_W-1:0]     prod_q;
  logic                         pvld_q;
  logic signed [ACC_W-1:0]      acc_q, sum_s, rnd_s;
  logic signed [OUT_WIDTH-1:0]  res_s, data_q;
  logic                         val_q, ovf_q;
  logic                         accept_s, overrun_s, done_s;

  // ROM is addressed with the next tap index so its read latency lines up with the MAC cycle.
  cic_comp_coef_rom #(
    .COEF_WIDTH(COEF_WIDTH),
    .ADDR_W    (TW)
  ) u_rom (
    .clk_i  (clk_i),
    .rst_n_i(rst_n_i),
    .en_i   (en_i),
    .addr_i (tap_d),
    .coef_o (coef_s)
  );

  assign samp_s = line_q[rptr_q];

  always_comb begin
    state_d   = state_q;
    tap_d     = tap_q;
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    accept_s  = 1'b0;
    overrun_s = 1'b0;
    done_s    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        tap_d = '0;
        if (val_i) begin
          accept_s = 1'b1;
          state_d  = ST_MAC;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_MAC: begin
        overrun_s = val_i;
        rptr_d    = (rptr_q == '0) ? LAST : rptr_q - TW'(1);
        if (tap_q == LAST) begin
          state_d = ST_DRAIN;
        end else begin
          tap_d = tap_q + TW'(1);
        end
      end
      ST_DRAIN: begin
        overrun_s = val_i;
        state_d   = ST_ROUND;
      end
      ST_ROUND: begin
        done_s = 1'b1;
        tap_d  = '0;
        if (val_i) begin
          accept_s = 1'b1;
          state_d  = ST_MAC;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (accept_s) begin
      rptr_d = wptr_q;
      wptr_d = (wptr_q == LAST) ? '0 : wptr_q + TW'(1);
    end else begin
      wptr_d = wptr_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      tap_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      ovf_q   <= 1'b0;
    end else if (en_i) begin
      state_q <= state_d;
      tap_q   <= tap_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      // An overrun in the same cycle as a clear wins.
      if (overrun_s) begin
        ovf_q <= 1'b1;
      end else if (clr_i) begin
        ovf_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < NTAPS; i++) line_q[i] <= '0;
    end else if (en_i && accept_s) begin
      line_q[wptr_q] <= data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      prod_q <= '0;
      pvld_q <= 1'b0;
      acc_q  <= '0;
      data_q <= '0;
      val_q  <= 1'b0;
    end else begin
      val_q <= en_i & done_s;
      if (en_i) begin
        pvld_q <= (state_q == ST_MAC);
        if (state_q == ST_MAC) begin
          prod_q <= PROD_W'(coef_s) * PROD_W'(samp_s);
        end
        if (accept_s) begin
          acc_q <= '0;
        end else if (pvld_q) begin
          acc_q <= acc_q + ACC_W'(prod_q);
        end
        if (done_s) begin
          data_q <= res_s;
        end
      end
    end
  end

  assign sum_s = acc_q + RND_BIAS;
  assign rnd_s = sum_s >>> (COEF_WIDTH - 1);

`ifdef CIC_COMP_FIR_SAT_EN
  localparam logic signed [ACC_W-1:0] OUT_MAX = ACC_W'({(OUT_WIDTH-1){1'b1}});
  localparam logic signed [ACC_W-1:0] OUT_MIN = ~OUT_MAX;

  always_comb begin
    if (rnd_s > OUT_MAX) begin
      res_s = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    end else if (rnd_s < OUT_MIN) begin
      res_s = {1'b1, {(OUT_WIDTH-1){1'b0}}};
    end else begin
      res_s = rnd_s[OUT_WIDTH-1:0];
    end
  end
`else
  logic rnd_unused_s;
  assign res_s        = rnd_s[OUT_WIDTH-1:0];
  assign rnd_unused_s = ^rnd_s[ACC_W-1:OUT_WIDTH];
`endif

  assign data_o = data_q;
  assign val_o  = val_q;
  assign busy_o = (state_q != ST_IDLE);
  assign ovf_o  = ovf_q;

endmodule
